// File: rtl/mac_stream_engine.sv
// Streaming multi-lane dot-product engine: pipelined lane products, accumulator,
// bias add and saturate/truncate to OUTW, with framing-error detection.
module mac_stream_engine #(
  parameter int unsigned DW      = 16,
  parameter int unsigned LANES   = 2,
  parameter int unsigned VLEN    = 32,
  parameter int unsigned ACCW    = 40,
  parameter int unsigned OUTW    = 32,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic                  start,
  input  logic                  mode_signed,
  input  logic                  sat_en,
  input  logic [DW-1:0]         bias,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [LANES*DW-1:0]   s_a,
  input  logic [LANES*DW-1:0]   s_b,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUTW-1:0]       m_data,
  output logic                  m_ovf,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned NBEATS = VLEN / LANES;
  localparam int unsigned CW     = $clog2(NBEATS + 1);
  // One lane product of (DW+1)-bit extended operands fits in 2*DW+1 signed bits.
  localparam int unsigned PRW    = 2 * DW + 2;
  localparam int unsigned PW     = 2 * DW + 1 + $clog2(LANES);
  localparam int unsigned TW     = ACCW + 1;

  localparam logic signed [TW-1:0] SMAX = $signed({{(TW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}});
  localparam logic signed [TW-1:0] SMIN = $signed({{(TW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}});
  localparam logic signed [TW-1:0] UMAX = $signed({{(TW-OUTW){1'b0}}, {OUTW{1'b1}}});

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                    state;
  logic                      mode_r;
  logic                      sat_r;
  logic [DW-1:0]             bias_r;
  logic [CW-1:0]             cnt;
  logic signed [ACCW-1:0]    acc;
  logic [MUL_LAT-1:0]        pv;
  logic signed [PW-1:0]      pd [MUL_LAT];
  logic                      fin;
  logic signed [TW-1:0]      tot_r;

  logic signed [DW:0]        ea   [LANES];
  logic signed [DW:0]        eb   [LANES];
  logic signed [PRW-1:0]     prod [LANES];
  logic signed [PW-1:0]      beat_sum;
  logic                      accept;
  logic                      last_cnt;
  logic                      pipe_empty;
  logic signed [TW-1:0]      bias_ext;
  logic signed [TW-1:0]      tot_c;
  logic                      ovf_c;
  logic [OUTW-1:0]           clamp_c;

  // Per-beat sum of lane products, operands extended per the latched mode.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      ea[i]    = $signed({mode_r & s_a[i*DW+DW-1], s_a[i*DW +: DW]});
      eb[i]    = $signed({mode_r & s_b[i*DW+DW-1], s_b[i*DW +: DW]});
      prod[i]  = PRW'(ea[i]) * PRW'(eb[i]);
      beat_sum = beat_sum + PW'(prod[i]);
    end
  end

  assign accept     = s_valid & s_ready;
  assign last_cnt   = (cnt == CW'(NBEATS - 1));
  assign pipe_empty = ~|pv;
  assign bias_ext   = $signed({{(TW-DW){mode_r & bias_r[DW-1]}}, bias_r});
  assign tot_c      = $signed({acc[ACCW-1], acc}) + bias_ext;

  // Range check and clamp value for the registered total.
  always_comb begin
    ovf_c   = 1'b0;
    clamp_c = UMAX[OUTW-1:0];
    if (mode_r) begin
      ovf_c   = (tot_r > SMAX) || (tot_r < SMIN);
      clamp_c = tot_r[TW-1] ? SMIN[OUTW-1:0] : SMAX[OUTW-1:0];
    end else begin
      ovf_c   = (tot_r > UMAX);
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state   <= IDLE;
      mode_r  <= 1'b0;
      sat_r   <= 1'b0;
      bias_r  <= '0;
      cnt     <= '0;
      acc     <= '0;
      pv      <= '0;
      for (int i = 0; i < int'(MUL_LAT); i++) pd[i] <= '0;
      fin     <= 1'b0;
      tot_r   <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ovf   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      // Free-running product pipeline; never stalls.
      pv[0] <= accept;
      pd[0] <= beat_sum;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (pv[MUL_LAT-1]) acc <= acc + ACCW'(pd[MUL_LAT-1]);

      case (state)
        IDLE: begin
          if (start) begin
            mode_r  <= mode_signed;
            sat_r   <= sat_en;
            bias_r  <= bias;
            acc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + CW'(1);
            if (s_last || last_cnt) begin
              if (s_last != last_cnt) err <= 1'b1;
              s_ready <= 1'b0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Two steps: bias add once the pipeline is empty, then range/clamp.
          if (fin) begin
            fin     <= 1'b0;
            m_data  <= (sat_r && ovf_c) ? clamp_c : tot_r[OUTW-1:0];
            m_ovf   <= ovf_c;
            m_valid <= 1'b1;
            state   <= OUT;
          end else if (pipe_empty) begin
            tot_r <= tot_c;
            fin   <= 1'b1;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_stream_engine.sv
// Scoreboard bench for mac_stream_engine: OUTW=32 and OUTW=16 instances share stimulus.
module tb_mac_stream_engine;
  localparam int DW = 16, LANES = 2, VLEN = 32, ML = 4, NB = VLEN / LANES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start, mode_signed, sat_en, s_valid, s_last, m_ready;
  logic [DW-1:0] bias;
  logic [LANES*DW-1:0] s_a, s_b;
  logic s_ready, m_valid, m_ovf, busy, err;
  logic [31:0] m_data;
  logic s_ready16, m_valid16, m_ovf16, busy16, err16;
  logic [15:0] m_data16;

  always #5 clk = ~clk;

  mac_stream_engine u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .start(start), .mode_signed(mode_signed),
    .sat_en(sat_en), .bias(bias), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a),
    .s_b(s_b), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_ovf(m_ovf), .busy(busy), .err(err));

  mac_stream_engine #(.OUTW(16)) u_dut16 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .start(start), .mode_signed(mode_signed),
    .sat_en(sat_en), .bias(bias), .s_valid(s_valid), .s_ready(s_ready16), .s_a(s_a),
    .s_b(s_b), .s_last(s_last), .m_valid(m_valid16), .m_ready(m_ready), .m_data(m_data16),
    .m_ovf(m_ovf16), .busy(busy16), .err(err16));

  typedef struct {
    logic [31:0] d32;
    logic        o32;
    logic [15:0] d16;
    logic        o16;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  logic [15:0] a_mem [VLEN];
  logic [15:0] b_mem [VLEN];

  function automatic longint ext16(input logic [15:0] v, input logic s);
    if (s) return longint'($signed(v));
    return longint'({48'd0, v});
  endfunction

  function automatic logic [63:0] sat_model(input longint tot, input logic s, input logic sat,
                                            input int w, output logic o);
    longint one, mx, mn;
    one = 1;
    mx  = s ? (one <<< (w - 1)) - 1 : (one <<< w) - 1;
    mn  = s ? -(one <<< (w - 1)) : 0;
    o   = (tot > mx) || (tot < mn);
    if (sat && o) return (tot > mx) ? mx : mn;
    return tot;
  endfunction

  task automatic fill(input logic [15:0] av, input logic [15:0] bv);
    for (int i = 0; i < VLEN; i++) begin
      a_mem[i] = av;
      b_mem[i] = bv;
    end
  endtask

  // Drives one vector, pushes the model result, and measures edges from final accept to m_valid.
  task automatic run_vec(input logic sgn, input logic sat, input logic [15:0] bs, input int last_at,
                         input bit rnd, input bit start_mid, input int abort_at,
                         output int lat, output bit to);
    int consumed, b, guard;
    longint sum;
    logic [63:0] r;
    logic o, rdy;
    bit v;
    exp_t e;
    consumed = (last_at >= 1 && last_at <= NB) ? last_at : NB;
    to = 1'b0;
    lat = -1;
    @(negedge clk);
    start = 1'b1; mode_signed = sgn; sat_en = sat; bias = bs;
    @(negedge clk);
    start = 1'b0; mode_signed = ~sgn; sat_en = ~sat; bias = ~bs;
    b = 0;
    guard = 0;
    while (b < consumed && !to && !(abort_at > 0 && b == abort_at)) begin
      v = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_valid = v;
      s_a = {a_mem[2*b+1], a_mem[2*b]};
      s_b = {b_mem[2*b+1], b_mem[2*b]};
      s_last = v && (b + 1 == last_at);
      start = start_mid && (b == 3);
      rdy = s_ready;
      @(posedge clk);
      if (v && rdy) b++;
      guard++;
      if (guard > 500) to = 1'b1;
      if (b < consumed && !to && !(abort_at > 0 && b == abort_at)) @(negedge clk);
    end
    #1;
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    if (abort_at > 0) return;
    sum = 0;
    for (int i = 0; i < consumed * LANES; i++) sum += ext16(a_mem[i], sgn) * ext16(b_mem[i], sgn);
    sum += ext16(bs, sgn);
    r = sat_model(sum, sgn, sat, 32, o);
    e.d32 = r[31:0]; e.o32 = o;
    r = sat_model(sum, sgn, sat, 16, o);
    e.d16 = r[15:0]; e.o16 = o;
    e.err = (last_at != NB);
    sb.push_back(e);
    lat = 0;
    while (!m_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!m_valid) to = 1'b1;
  endtask

  task automatic handshake();
    @(negedge clk); m_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); m_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({s_ready, m_valid, m_ovf, busy, err} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {s_ready, m_valid, m_ovf, busy, err});
    else passed++;
    checks++;
    if (m_data !== 32'd0 || m_data16 !== 16'd0)
      $display("FAIL reset_data got %h/%h want 0", m_data, m_data16);
    else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL reset_release got busy=%b m_valid=%b want 0/0", busy, m_valid);
    else passed++;
  endtask

  task automatic test_basic();
    int lat; bit to; exp_t e;
    fill(16'd1, 16'd2);
    run_vec(1'b1, 1'b1, 16'd5, NB, 1'b0, 1'b0, 0, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != ML + 2) $display("FAIL basic_latency got %0d want %0d", lat, ML + 2);
    else passed++;
    checks++;
    if (m_data !== 32'd69 || m_data !== e.d32 || m_ovf !== 1'b0)
      $display("FAIL basic_data got %0d ovf=%b want 69 ovf=0", m_data, m_ovf);
    else passed++;
    checks++;
    if (err !== e.err || busy !== 1'b1) $display("FAIL basic_err got err=%b busy=%b want 0/1", err, busy);
    else passed++;
    handshake();
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_release got m_valid=%b busy=%b want 0/0", m_valid, busy);
    else passed++;
  endtask

  task automatic test_signed();
    int lat; bit to; exp_t e; logic sg;
    fill(16'hFFFD, 16'd4);
    for (int k = 0; k < 2; k++) begin
      sg = (k == 0);
      run_vec(sg, 1'b1, 16'hFFFF, NB, 1'b0, 1'b0, 0, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat != ML + 2) $display("FAIL signed%0d_latency got %0d want %0d", k, lat, ML + 2);
      else passed++;
      checks++;
      if (m_data !== e.d32 || m_ovf !== e.o32)
        $display("FAIL signed%0d_data32 got %h/%b want %h/%b", k, m_data, m_ovf, e.d32, e.o32);
      else passed++;
      checks++;
      if (m_data16 !== e.d16 || m_ovf16 !== e.o16)
        $display("FAIL signed%0d_data16 got %h/%b want %h/%b", k, m_data16, m_ovf16, e.d16, e.o16);
      else passed++;
      if (k == 0) begin
        checks++;
        if (m_data !== 32'hFFFF_FE7F) $display("FAIL signed_minus385 got %h want fffffe7f", m_data);
        else passed++;
      end
      handshake();
    end
  endtask

  task automatic test_saturate();
    int lat; bit to; exp_t e; logic st;
    fill(16'h7FFF, 16'h7FFF);
    for (int k = 0; k < 2; k++) begin
      st = (k == 0);
      run_vec(1'b1, st, 16'd0, NB, 1'b0, 1'b0, 0, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || m_data16 !== e.d16 || m_ovf16 !== 1'b1)
        $display("FAIL sat%0d_data16 got %h/%b want %h/1", k, m_data16, m_ovf16, e.d16);
      else passed++;
      checks++;
      if (m_data !== e.d32 || m_ovf !== e.o32)
        $display("FAIL sat%0d_data32 got %h/%b want %h/%b", k, m_data, m_ovf, e.d32, e.o32);
      else passed++;
      handshake();
    end
  endtask

  task automatic test_framing();
    int lat; bit to; exp_t e;
    int last_tab [3] = '{8, 0, NB};
    fill(16'd3, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      run_vec(1'b1, 1'b0, 16'd7, last_tab[k], 1'b0, 1'b0, 0, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat != ML + 2) $display("FAIL frame%0d_latency got %0d want %0d", k, lat, ML + 2);
      else passed++;
      checks++;
      if (m_data !== e.d32) $display("FAIL frame%0d_data got %h want %h", k, m_data, e.d32);
      else passed++;
      checks++;
      if (err !== e.err || err16 !== e.err) $display("FAIL frame%0d_err got %b want %b", k, err, e.err);
      else passed++;
      handshake();
      checks++;
      if (err !== e.err) $display("FAIL frame%0d_err_sticky got %b want %b", k, err, e.err);
      else passed++;
    end
  endtask

  task automatic test_back_to_back_stall();
    int lat; bit to; exp_t e;
    fill(16'd1, 16'd2);
    run_vec(1'b1, 1'b1, 16'd5, NB, 1'b1, 1'b1, 0, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != ML + 2) $display("FAIL stall_latency got %0d want %0d", lat, ML + 2);
    else passed++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); start = (k == 4);
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== e.d32 || m_ovf !== e.o32)
        $display("FAIL stall_hold%0d got v=%b %0d want v=1 %0d", k, m_valid, m_data, e.d32);
      else passed++;
    end
    @(negedge clk); start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stall_start_at_out got m_valid=%b busy=%b want 0/0", m_valid, busy);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) $display("FAIL stall_idle got busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; bit to; bit seen; exp_t e;
    fill(16'd1, 16'd2);
    run_vec(1'b1, 1'b1, 16'd5, NB, 1'b0, 1'b0, 7, lat, to);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, m_valid, m_ovf, busy, err} !== 5'b0 || m_data !== 32'd0)
      $display("FAIL midreset_async got %b data=%h want 00000 data=0",
               {s_ready, m_valid, m_ovf, busy, err}, m_data);
    else passed++;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (m_valid || m_valid16 || busy) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL midreset_spurious got activity=1 want 0");
    else passed++;
    run_vec(1'b1, 1'b1, 16'd5, NB, 1'b0, 1'b0, 0, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != ML + 2 || m_data !== 32'd69 || m_data !== e.d32 || err !== 1'b0)
      $display("FAIL midreset_fresh got lat=%0d data=%0d err=%b want %0d 69 0", lat, m_data, err, ML + 2);
    else passed++;
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    start = 1'b0; mode_signed = 1'b0; sat_en = 1'b0; bias = '0;
    s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_saturate();
    test_framing();
    test_back_to_back_stall();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mac_stream_engine.md
MAC_STREAM_ENGINE -- requirements
Module: mac_stream_engine

Interface
REQ-001 SHALL have parameter DW, default 16: operand width in bits.
REQ-002 SHALL have parameter LANES, default 2: operand pairs per input beat.
REQ-003 SHALL have parameter VLEN, default 32: elements per dot product; must be a multiple of LANES.
REQ-004 SHALL have parameter ACCW, default 40: accumulator width; must be at least 2*DW+clog2(VLEN)+1.
REQ-005 SHALL have parameter OUTW, default 32: result width.
REQ-006 SHALL have parameter MUL_LAT, default 4: product pipeline depth in cycles; must be at least 1.
REQ-007 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-008 S_AXI_ARESET  in  1  reset; asynchronous and active-high.
REQ-009 start  in  1  single-cycle start pulse.
REQ-010 mode_signed  in  1  1 = two's-complement operands and bias; 0 = unsigned.
REQ-011 sat_en  in  1  1 = saturate result to OUTW; 0 = truncate.
REQ-012 bias  in  DW  bias added once per vector.
REQ-013 s_valid / s_ready  in / out  1 / 1  input beat handshake.
REQ-014 s_a, s_b  in  LANES*DW  packed operands; lane i occupies bits [i*DW +: DW].
REQ-015 s_last  in  1  marks the final beat of a vector.
REQ-016 m_valid / m_ready  out / in  1 / 1  result handshake.
REQ-017 m_data  out  OUTW  result.
REQ-018 m_ovf  out  1  result did not fit in OUTW.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 err  out  1  sticky framing error.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DRAIN and OUT.
REQ-022 IDLE: start=1 latches mode_signed, sat_en and bias, clears the accumulator, beat counter and err, then moves to RUN. A start pulse outside IDLE SHALL be ignored.
REQ-023 s_ready SHALL be 1 only in RUN; a beat is accepted when s_valid and s_ready are both 1 at a clock edge.
REQ-024 Each accepted beat SHALL form the sum of its LANES products, sign- or zero-extended per mode, and enter a MUL_LAT-stage pipeline with a valid bit. The pipeline is never stalled.
REQ-025 Each pipeline-output sum SHALL be added into the ACCW-bit accumulator on the edge it exits the pipeline.
REQ-026 Beat counter SHALL reach VLEN/LANES on the final beat. RUN moves to DRAIN on the edge that accepts either the counted final beat or a beat with s_last=1, whichever comes first.
REQ-027 err SHALL be set if s_last=1 arrives before the counted final beat (the vector ends early with the partial sum).
REQ-028 err SHALL be set if the counted final beat arrives with s_last=0.
REQ-029 DRAIN SHALL wait until no pipeline valid bits remain. It then computes acc + extended bias, saturates or truncates to OUTW, sets m_ovf, and enters OUT.
REQ-030 m_valid SHALL rise exactly MUL_LAT+2 edges after the edge that accepted the final beat.
REQ-031 Saturation: signed mode clamps to [-2^(OUTW-1), 2^(OUTW-1)-1]; unsigned mode clamps to 2^OUTW-1.
REQ-032 m_ovf SHALL be 1 whenever the clamp would apply, whether sat_en is 1 or 0.
REQ-033 OUT: m_valid, m_data and m_ovf SHALL be held stable until m_ready=1. On that edge m_valid drops and the FSM returns to IDLE.
REQ-034 A start pulse on the same edge as the OUT handshake SHALL be ignored; a new start is accepted in IDLE only.
REQ-035 err SHALL stay set until the next accepted start.

Reset
REQ-036 S_AXI_ARESET=1 SHALL immediately, with no clock required, force: FSM=IDLE; s_ready, m_valid, m_ovf, busy, err = 0; m_data = 0; accumulator, counters and pipeline valid bits = 0.
REQ-037 Reset asserted mid-RUN or mid-DRAIN SHALL discard the operation; after deassertion there SHALL be no spurious m_valid.

Verification
REQ-038 Defaults, signed: a_k=1, b_k=2 for all 32 elements, bias=5, s_last on beat 16 -> m_data=69, m_ovf=0, err=0, m_valid at MUL_LAT+2 edges after the last beat.
REQ-039 Signed: a=-3 (0xFFFD), b=4, bias=-1 -> m_data=-385. Same data with mode_signed=0 -> large positive unsigned result, no ovf at OUTW=32 (check against model).
REQ-040 OUTW=16, sat_en=1, signed: a=b=0x7FFF, bias=0 -> m_data=0x7FFF, m_ovf=1. With sat_en=0 -> truncated low 16 bits, m_ovf=1.
REQ-041 s_last on beat 8 of 16 -> sum of the first 16 elements plus bias, err=1. 16 beats without s_last -> full result, err=1. Next start clears err.
REQ-042 s_valid toggled randomly and m_ready held low 10 cycles -> result identical to REQ-038 and stable while stalled; start pulses during RUN and OUT ignored.
REQ-043 Reset asserted mid-RUN at beat 7 -> all outputs 0 asynchronously; after release no m_valid; a fresh start gives the correct REQ-038 result.
